// File: rtl/store_rmw_ctrl.sv
// Store sequencer beside the main control FSM: SB/SH read the target word into MDR and
// write back the merged word, SW writes B directly, misaligned/illegal stores abort.
module store_rmw_ctrl #(
    parameter int MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic        mdr_load,
    output logic        ss_cmd,
    output logic        wdata_sel
);

    localparam logic [1:0] OP_SH = 2'b01;
    localparam logic [1:0] OP_SW = 2'b10;
    localparam logic [1:0] OP_XX = 2'b11;
    localparam logic [2:0] RD_LAT_M1 = 3'(MEM_RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_RD,
        S_LATCH,
        S_WR,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        abort_q, abort_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_wr_q, mem_wr_d;
    logic        mdr_load_q, mdr_load_d;
    logic        ss_cmd_q, ss_cmd_d;
    logic        wdata_sel_q, wdata_sel_d;

    function automatic logic store_rejected(input logic [1:0] o, input logic [1:0] a);
        return (o == OP_XX) ||
               ((o == OP_SH) && a[0]) ||
               ((o == OP_SW) && (a != 2'b00));
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    addr_d  = addr;
                    abort_d = 1'b0;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (store_rejected(op_q, addr_q[1:0])) begin
                    abort_d = 1'b1;
                    state_d = S_FIN;
                end else if (op_q == OP_SW) begin
                    state_d = S_WR;
                end else begin
                    cnt_d   = RD_LAT_M1;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_LATCH;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_LATCH: state_d = S_WR;
            S_WR:    state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FIN);
        err_d       = (state_d == S_FIN) && abort_d;
        mem_wr_d    = (state_d == S_WR);
        mdr_load_d  = (state_d == S_LATCH);
        mem_addr_d  = busy_d ? addr_d : 32'h0;
        ss_cmd_d    = busy_d && (op_d == OP_SH);
        wdata_sel_d = busy_d && (op_d == OP_SW);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            addr_q      <= 32'h0;
            cnt_q       <= 3'd0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wr_q    <= 1'b0;
            mdr_load_q  <= 1'b0;
            ss_cmd_q    <= 1'b0;
            wdata_sel_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wr_q    <= mem_wr_d;
            mdr_load_q  <= mdr_load_d;
            ss_cmd_q    <= ss_cmd_d;
            wdata_sel_q <= wdata_sel_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mdr_load  = mdr_load_q;
    assign ss_cmd    = ss_cmd_q;
    assign wdata_sel = wdata_sel_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: two instances (read latency 1 and 3) against a per-transaction
// timeline model, plus literal cycle checks of the directed store scenarios.
`timescale 1ns/1ps
module tb_store_rmw_ctrl;

    localparam int B_BUSY = 38;
    localparam int B_DONE = 37;
    localparam int B_ERR  = 36;
    localparam int B_WR   = 35;
    localparam int B_MDR  = 34;
    localparam int B_SS   = 33;
    localparam int B_WS   = 32;
    localparam int HMAX   = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        st   [2];
    logic [1:0]  opv  [2];
    logic [31:0] ad   [2];
    logic        busy_o [2];
    logic        done_o [2];
    logic        err_o  [2];
    logic [31:0] ma_o   [2];
    logic        wr_o   [2];
    logic        mdr_o  [2];
    logic        ss_o   [2];
    logic        ws_o   [2];

    store_rmw_ctrl #(.MEM_RD_LAT(1)) u_lat1 (
        .clk(clk), .reset_n(reset_n), .start(st[0]), .op(opv[0]), .addr(ad[0]),
        .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]), .mem_addr(ma_o[0]),
        .mem_wr(wr_o[0]), .mdr_load(mdr_o[0]), .ss_cmd(ss_o[0]), .wdata_sel(ws_o[0])
    );

    store_rmw_ctrl #(.MEM_RD_LAT(3)) u_lat3 (
        .clk(clk), .reset_n(reset_n), .start(st[1]), .op(opv[1]), .addr(ad[1]),
        .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]), .mem_addr(ma_o[1]),
        .mem_wr(wr_o[1]), .mdr_load(mdr_o[1]), .ss_cmd(ss_o[1]), .wdata_sel(ws_o[1])
    );

    int          cyc;
    int          n_tests;
    int          n_fail;
    bit          act [2];
    int          t0  [2];
    logic [1:0]  mop [2];
    logic [31:0] mad [2];
    logic [38:0] hist [2][HMAX];

    function automatic int lat(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit is_bad(logic [1:0] o, logic [31:0] a);
        return (o == 2'b11) || (o == 2'b01 && a[0]) || (o == 2'b10 && a[1:0] != 2'b00);
    endfunction

    // Number of busy cycles a transaction occupies; the last one carries done.
    function automatic int dur(int k);
        if (is_bad(mop[k], mad[k])) return 2;
        if (mop[k] == 2'b10) return 3;
        return 4 + lat(k);
    endfunction

    function automatic logic [38:0] expect_out(int k);
        logic [38:0] e;
        int d;
        e = '0;
        if (reset_n !== 1'b1 || !act[k]) return e;
        d = cyc - t0[k] + 1;
        if (d < 1 || d > dur(k)) return e;
        e[B_BUSY]  = 1'b1;
        e[31:0]    = mad[k];
        e[B_SS]    = (mop[k] == 2'b01);
        e[B_WS]    = (mop[k] == 2'b10);
        if (d == dur(k)) begin
            e[B_DONE] = 1'b1;
            e[B_ERR]  = is_bad(mop[k], mad[k]);
        end
        if (!is_bad(mop[k], mad[k])) begin
            if (mop[k] == 2'b10) begin
                e[B_WR] = (d == 2);
            end else begin
                e[B_MDR] = (d == 2 + lat(k));
                e[B_WR]  = (d == 3 + lat(k));
            end
        end
        return e;
    endfunction

    function automatic logic [38:0] obs(int k);
        return {busy_o[k], done_o[k], err_o[k], wr_o[k], mdr_o[k], ss_o[k], ws_o[k], ma_o[k]};
    endfunction

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic pin(string nm, int k, int idx, int bp, logic v);
        chk(nm, {63'b0, hist[k][idx][bp]}, {63'b0, v});
    endtask

    function automatic int count_bit(int k, int lo, int hi, int bp);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) n += int'(hist[k][i][bp]);
        return n;
    endfunction

    // One clock: advance the model on the rising edge, compare both instances on the falling edge.
    task automatic tick();
        logic [38:0] o;
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (reset_n !== 1'b1) begin
                act[k] = 1'b0;
            end else if (!(act[k] && (cyc - t0[k]) >= 1 && (cyc - t0[k]) <= dur(k))) begin
                act[k] = 1'b0;
                if (st[k]) begin
                    act[k] = 1'b1;
                    t0[k]  = cyc;
                    mop[k] = opv[k];
                    mad[k] = ad[k];
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            o = obs(k);
            if (cyc < HMAX) hist[k][cyc] = o;
            chk($sformatf("dut%0d_cyc%0d", k, cyc), {25'b0, o}, {25'b0, expect_out(k)});
        end
    endtask

    task automatic issue(int k, logic [1:0] o, logic [31:0] a, output int base);
        base   = cyc;
        st[k]  = 1'b1;
        opv[k] = o;
        ad[k]  = a;
        tick();
        st[k]  = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        logic [1:0]  bad_op [3];
        logic [31:0] bad_ad [3];
        bad_op = '{2'b01, 2'b10, 2'b11};
        bad_ad = '{32'h23, 32'h42, 32'h80};
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'b0; opv[k] = 2'b00; ad[k] = 32'h0;
            act[k] = 1'b0; t0[k] = 0; mop[k] = 2'b00; mad[k] = 32'h0;
        end
        st[0] = 1'b1; st[1] = 1'b1;
        repeat (3) tick();
        chk("reset_outputs_dut0", {25'b0, obs(0)}, 64'h0);
        chk("reset_outputs_dut1", {25'b0, obs(1)}, 64'h0);
        st[0] = 1'b0; st[1] = 1'b0;
        reset_n = 1'b1;
        tick();

        // SB at 0x10, read latency 1
        issue(0, 2'b00, 32'h10, b);
        repeat (7) tick();
        pin("t1_mdr_c2", 0, b + 2, B_MDR, 1'b0);
        pin("t1_mdr_c3", 0, b + 3, B_MDR, 1'b1);
        pin("t1_wr_c3",  0, b + 3, B_WR,  1'b0);
        pin("t1_wr_c4",  0, b + 4, B_WR,  1'b1);
        pin("t1_mdr_c4", 0, b + 4, B_MDR, 1'b0);
        pin("t1_ss_c4",  0, b + 4, B_SS,  1'b0);
        pin("t1_ws_c4",  0, b + 4, B_WS,  1'b0);
        pin("t1_done_c5", 0, b + 5, B_DONE, 1'b1);
        pin("t1_err_c5",  0, b + 5, B_ERR,  1'b0);
        pin("t1_busy_c6", 0, b + 6, B_BUSY, 1'b0);
        chk("t1_addr_c1", {32'b0, hist[0][b + 1][31:0]}, 64'h10);
        chk("t1_addr_c5", {32'b0, hist[0][b + 5][31:0]}, 64'h10);

        // SH at 0x22, read latency 3
        issue(1, 2'b01, 32'h22, b);
        repeat (8) tick();
        pin("t2_mdr_c4", 1, b + 4, B_MDR, 1'b0);
        pin("t2_mdr_c5", 1, b + 5, B_MDR, 1'b1);
        pin("t2_wr_c6",  1, b + 6, B_WR,  1'b1);
        pin("t2_ss_c6",  1, b + 6, B_SS,  1'b1);
        pin("t2_done_c7", 1, b + 7, B_DONE, 1'b1);
        chk("t2_wr_count", count_bit(1, b + 1, b + 9, B_WR), 1);

        // SW at 0x40
        issue(0, 2'b10, 32'h40, b);
        repeat (5) tick();
        pin("t3_wr_c2", 0, b + 2, B_WR, 1'b1);
        pin("t3_ws_c2", 0, b + 2, B_WS, 1'b1);
        pin("t3_done_c3", 0, b + 3, B_DONE, 1'b1);
        chk("t3_mdr_count", count_bit(0, b + 1, b + 6, B_MDR), 0);

        // Rejected stores: misaligned SH/SW and illegal op
        for (int i = 0; i < 3; i++) begin
            issue(0, bad_op[i], bad_ad[i], b);
            repeat (3) tick();
            pin($sformatf("t4_done_c2_%0d", i), 0, b + 2, B_DONE, 1'b1);
            pin($sformatf("t4_err_c2_%0d", i),  0, b + 2, B_ERR,  1'b1);
            pin($sformatf("t4_busy_c3_%0d", i), 0, b + 3, B_BUSY, 1'b0);
            chk($sformatf("t4_wr_mdr_%0d", i),
                count_bit(0, b + 1, b + 4, B_WR) + count_bit(0, b + 1, b + 4, B_MDR), 0);
        end

        // start held high through an SB with latency 3
        b = cyc;
        st[1] = 1'b1; opv[1] = 2'b00; ad[1] = 32'h104;
        repeat (9) tick();
        st[1] = 1'b0;
        repeat (12) tick();
        chk("t5_wr_count",   count_bit(1, b + 1, b + 7, B_WR), 1);
        chk("t5_done_count", count_bit(1, b + 1, b + 7, B_DONE), 1);
        pin("t5_busy_c8", 1, b + 8, B_BUSY, 1'b0);
        pin("t5_busy_c9", 1, b + 9, B_BUSY, 1'b1);
        pin("t5_wr2_c14", 1, b + 14, B_WR, 1'b1);
        chk("t5_total_wr", count_bit(1, b + 1, b + 21, B_WR), 2);

        // Reset in the middle of the read phase
        issue(1, 2'b00, 32'h200, b);
        tick();
        reset_n = 1'b0;
        #1;
        chk("t6_busy_async", {63'b0, busy_o[1]}, 64'h0);
        chk("t6_addr_async", {32'b0, ma_o[1]}, 64'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        issue(1, 2'b10, 32'h300, b);
        repeat (4) tick();
        pin("t6_sw_wr_c2", 1, b + 2, B_WR, 1'b1);
        pin("t6_sw_done_c3", 1, b + 3, B_DONE, 1'b1);

        // Randomized traffic with occasional reset pulses
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 2; k++) begin
                st[k]  = ($urandom_range(0, 2) == 0);
                opv[k] = 2'($urandom_range(0, 3));
                ad[k]  = $urandom;
                if ($urandom_range(0, 1) == 1) ad[k][1:0] = 2'b00;
            end
            reset_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        st[0] = 1'b0; st[1] = 1'b0; reset_n = 1'b1;
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
